mux_scan_nto1: RTL and testbench
================================

Name: mux_scan_nto1

Overview:
Parametrised, registered N-to-1 channel multiplexer. It is the next generation of the team's 16-to-1 single-bit mux, generalised in channel count and data width, and it adds:
- a valid/ready output handshake;
- an auto-scan mode that steps through channels with a programmable dwell.

It sits between a bank of channel sources and a single downstream consumer, for example a serialiser or a monitor.

Parameters:
N_CH, 16, number of input channels (>=2)
DW, 1, data width per channel in bits
SEL_W, $clog2(N_CH), select/channel-index width (derived, do not override)
DWELL_W, 8, width of the dwell-count configuration input

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
datain  input  N_CH*DW  packed channel data; channel k occupies datain[k*DW +: DW]
in_valid  input  1  datain is valid this cycle
in_ready  output  1  block can accept a beat this cycle
mode  input  1  0 = FIXED (external select), 1 = SCAN (internal pointer)
select  input  SEL_W  channel index used in FIXED mode
cfg_dwell  input  DWELL_W  beats per channel in SCAN mode; 0 is treated as 1
outd  output  DW  registered selected data
out_ch  output  SEL_W  channel index that produced outd
out_valid  output  1  outd/out_ch valid
out_ready  input  1  consumer accepts the beat
sel_err  output  1  outd beat came from an out-of-range select (FIXED only)
scan_wrap  output  1  outd beat is the last dwell beat of channel N_CH-1 (SCAN only)

Behaviour:
- Reset (async assert, sync use after deassert): outd=0, out_ch=0, out_valid=0, sel_err=0, scan_wrap=0, scan pointer=0, dwell counter=0, FSM=FIXED.
- Single output register stage, latency 1 cycle from accepted input to outd.
- in_ready = !out_valid || out_ready (combinational).
- Accept = in_valid && in_ready. On accept, the output register loads, out_valid goes to 1, and out_ch, sel_err and scan_wrap are registered alongside outd.
- Output holding: out_valid && !out_ready with no accept leaves every output register stable. Ignore in_valid while stalled.
- Output clearing: out_valid clears after out_ready && out_valid with no accept in the same cycle.
- Simultaneous drain and accept in one cycle means back-to-back throughput of 1 beat/cycle.
- FSM states FIXED and SCAN. The mode input is sampled every cycle.
  - FIXED->SCAN on mode=1: pointer=0, dwell counter=0.
  - SCAN->FIXED on mode=0: the pointer is retained but unused.
  - A transition occurs even when no beat is accepted.
  - A beat accepted in the transition cycle uses the new mode: in SCAN it uses channel 0.
- FIXED: on accept, outd = datain[select*DW +: DW] and out_ch = select.
  - If select >= N_CH (only possible when N_CH is not a power of 2): outd=0, sel_err=1 for that beat.
- SCAN: on accept, outd = channel[pointer] and out_ch = pointer. The dwell counter increments.
  - When the dwell counter reaches max(cfg_dwell,1)-1: the counter resets to 0 and the pointer advances.
  - Pointer wrap: pointer N_CH-1 -> 0, and that beat carries scan_wrap=1. scan_wrap=0 otherwise.
- cfg_dwell changes are used from the next accept. If the current counter is already >= the new terminal value, the next accept advances the pointer.
- sel_err=0 in SCAN; scan_wrap=0 in FIXED.
- Reset asserted mid-stream drops any pending output beat immediately (out_valid=0 asynchronously).

Decomposition:
- Package mux_scan_pkg holds:
  - mode_e enum {MODE_FIXED=1'b0, MODE_SCAN=1'b1};
  - localparam function for SEL_W;
  - the dwell-zero-as-one rule as a function.
- One natural sub-module: mux_scan_ptr, holding the scan pointer, dwell counter and wrap detection (inputs: advance, cfg_dwell, clear; outputs: ptr, wrap). Datapath mux and output register stay in the top.

Test Plan:
- Reset/FIXED sweep: N_CH=16, DW=1, datain=16'h0001 shifted left once per 16 selects. Check:
  - out_valid=0 and outd=0 during rst;
  - out_ready=1 throughout;
  - outd=1 exactly when select equals the set bit, 1 cycle after accept, and out_ch=select.
- Backpressure: FIXED, select=3, datain channel 3=1. Hold out_ready=0 for 5 cycles and change select to 5 meanwhile. Check:
  - in_ready=0;
  - outd=1 and out_ch=3 stable for all 5 cycles;
  - after out_ready=1, the next beat has out_ch=5.
- SCAN dwell/wrap: cfg_dwell=2, in_valid=1, out_ready=1. Check:
  - out_ch sequence 0,0,1,1,...,15,15,0;
  - scan_wrap=1 only on the second out_ch=15 beat.
- Dwell zero and mode switch: cfg_dwell=0 gives out_ch 0,1,2. Then:
  - mode=0 with select=9 gives out_ch=9;
  - mode=1 again restarts at out_ch=0.
- Out-of-range: N_CH=10, DW=4, FIXED, select=12 gives outd=0 and sel_err=1. Then select=7 with channel 7=4'hA gives outd=4'hA and sel_err=0.
- Reset mid-operation: SCAN, cfg_dwell=3, assert rst asynchronously after out_ch=4 is output. Check:
  - out_valid drops the same cycle;
  - after release, the first beat has out_ch=0 and scan_wrap=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and helpers for the N-to-1 scanning mux.
//   mode_e     : FIXED (external select) / SCAN (internal pointer)
//   sel_width  : select/channel-index width for a given channel count
//   dwell_eff  : effective dwell length (a dwell of 0 behaves as 1)
package mux_scan_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SCAN  = 1'b1
  } mode_e;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned dwell_eff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// mux_scan_ptr: scan pointer and dwell counter for SCAN mode.
//   clk, rst     : clock, async active-high reset
//   clear_i      : entering SCAN this cycle; pointer/counter read as 0
//   advance_i    : a SCAN beat is accepted this cycle
//   cfg_dwell_i  : beats per channel (0 behaves as 1)
//   ptr_o        : channel index the current beat uses
//   wrap_o       : current beat is the last dwell beat of channel N_CH-1
module mux_scan_ptr
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic [DWELL_W-1:0] cfg_dwell_i,
  output logic [SEL_W-1:0]   ptr_o,
  output logic               wrap_o
);

  logic [SEL_W-1:0]   ptr_q, ptr_d, ptr_cur;
  logic [DWELL_W-1:0] cnt_q, cnt_d, cnt_cur, term;
  logic               last;

  always_comb begin
    // On mode entry the beat of the same cycle already sees channel 0.
    ptr_cur = clear_i ? '0 : ptr_q;
    cnt_cur = clear_i ? '0 : cnt_q;
    term    = DWELL_W'(dwell_eff(32'(cfg_dwell_i)) - 1);
    // >= so a dwell shortened below the running count advances at once.
    last    = (cnt_cur >= term);
    ptr_d   = ptr_cur;
    cnt_d   = cnt_cur;
    if (advance_i) begin
      if (last) begin
        cnt_d = '0;
        ptr_d = (ptr_cur == SEL_W'(N_CH - 1)) ? '0 : ptr_cur + 1'b1;
      end else begin
        cnt_d = cnt_cur + 1'b1;
      end
    end
  end

  assign ptr_o  = ptr_cur;
  assign wrap_o = last && (ptr_cur == SEL_W'(N_CH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered N-to-1 channel mux with valid/ready output
// handshake and an auto-scan mode with programmable dwell.
//   clk, rst            : clock, async active-high reset
//   datain              : packed channels, channel k at [k*DW +: DW]
//   in_valid / in_ready : input handshake (in_ready = !out_valid || out_ready)
//   mode                : 0 FIXED (use select), 1 SCAN (internal pointer)
//   select              : FIXED-mode channel index
//   cfg_dwell           : SCAN beats per channel (0 behaves as 1)
//   outd, out_ch        : registered data and the channel it came from
//   out_valid/out_ready : output handshake
//   sel_err             : FIXED beat from an out-of-range select (outd=0)
//   scan_wrap           : SCAN beat that is the last dwell beat of N_CH-1
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int N_CH    = 16,
  parameter int DW      = 1,
  parameter int SEL_W   = sel_width(N_CH),
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_CH*DW-1:0] datain,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   select,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [DW-1:0]      outd,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic               scan_wrap
);

  mode_e            state_q, state_d;
  logic             acc, entering;
  logic [SEL_W-1:0] ptr;
  logic             wrap;
  logic [DW-1:0]    fix_d, scan_d, outd_d;
  logic             fix_hit;
  logic [SEL_W-1:0] ch_d;
  logic             err_d, wrap_d;

  // mode is sampled every cycle; a beat in the switch cycle uses the new mode
  assign state_d  = mode ? MODE_SCAN : MODE_FIXED;
  assign entering = (state_q == MODE_FIXED) && (state_d == MODE_SCAN);
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;

  mux_scan_ptr #(.N_CH(N_CH), .SEL_W(SEL_W), .DWELL_W(DWELL_W)) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (entering),
    .advance_i  (acc && (state_d == MODE_SCAN)),
    .cfg_dwell_i(cfg_dwell),
    .ptr_o      (ptr),
    .wrap_o     (wrap)
  );

  always_comb begin
    fix_d   = '0;
    fix_hit = 1'b0;
    scan_d  = '0;
    // No channel match means select is beyond N_CH-1.
    for (int k = 0; k < N_CH; k++) begin
      if (select == SEL_W'(k)) begin
        fix_d   = datain[k*DW +: DW];
        fix_hit = 1'b1;
      end
      if (ptr == SEL_W'(k)) scan_d = datain[k*DW +: DW];
    end
    if (state_d == MODE_SCAN) begin
      outd_d = scan_d;
      ch_d   = ptr;
      err_d  = 1'b0;
      wrap_d = wrap;
    end else begin
      outd_d = fix_hit ? fix_d : '0;
      ch_d   = select;
      err_d  = !fix_hit;
      wrap_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MODE_FIXED;
      outd      <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        outd      <= outd_d;
        out_ch    <= ch_d;
        out_valid <= 1'b1;
        sel_err   <= err_d;
        scan_wrap <= wrap_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
module tb_mux_scan_nto1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 16 channels x 1 bit
  logic [15:0] a_din;
  logic        a_iv, a_ir, a_mode, a_ov, a_or, a_err, a_wrap;
  logic [3:0]  a_sel, a_ch;
  logic [7:0]  a_cfg;
  logic [0:0]  a_d;

  // DUT B: 10 channels x 4 bits
  logic [39:0] b_din;
  logic        b_iv, b_ir, b_mode, b_ov, b_or, b_err, b_wrap;
  logic [3:0]  b_sel, b_ch;
  logic [7:0]  b_cfg;
  logic [3:0]  b_d;

  mux_scan_nto1 #(.N_CH(16), .DW(1)) dut_a (
    .clk(clk), .rst(rst), .datain(a_din), .in_valid(a_iv), .in_ready(a_ir),
    .mode(a_mode), .select(a_sel), .cfg_dwell(a_cfg), .outd(a_d), .out_ch(a_ch),
    .out_valid(a_ov), .out_ready(a_or), .sel_err(a_err), .scan_wrap(a_wrap));

  mux_scan_nto1 #(.N_CH(10), .DW(4)) dut_b (
    .clk(clk), .rst(rst), .datain(b_din), .in_valid(b_iv), .in_ready(b_ir),
    .mode(b_mode), .select(b_sel), .cfg_dwell(b_cfg), .outd(b_d), .out_ch(b_ch),
    .out_valid(b_ov), .out_ready(b_or), .sel_err(b_err), .scan_wrap(b_wrap));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit         m_scan[2];
  int         m_ptr[2], m_cnt[2];
  bit         e_v[2], e_err[2], e_wrap[2];
  logic [3:0] e_d[2];
  int         e_ch[2];

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_scan[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      e_v[i] = 0; e_err[i] = 0; e_wrap[i] = 0; e_d[i] = 0; e_ch[i] = 0;
    end
  endtask

  task automatic mdl(input int i, input int n, input int dw, input logic [63:0] din,
                     input logic iv, input logic md, input int sel, input int cfg,
                     input logic ordy);
    bit acc;
    int term;
    logic [63:0] mask;
    mask = (64'd1 << dw) - 64'd1;
    acc  = iv && (!e_v[i] || ordy);
    if (md && !m_scan[i]) begin m_ptr[i] = 0; m_cnt[i] = 0; end
    m_scan[i] = md;
    if (acc) begin
      e_v[i] = 1;
      if (md) begin
        term      = (cfg == 0) ? 0 : cfg - 1;
        e_ch[i]   = m_ptr[i];
        e_d[i]    = 4'((din >> (m_ptr[i] * dw)) & mask);
        e_err[i]  = 0;
        e_wrap[i] = (m_cnt[i] >= term) && (m_ptr[i] == n - 1);
        if (m_cnt[i] >= term) begin
          m_cnt[i] = 0;
          m_ptr[i] = (m_ptr[i] + 1) % n;
        end else m_cnt[i]++;
      end else begin
        e_ch[i]   = sel;
        e_err[i]  = (sel >= n);
        e_d[i]    = (sel >= n) ? 4'd0 : 4'((din >> (sel * dw)) & mask);
        e_wrap[i] = 0;
      end
    end else if (ordy) e_v[i] = 0;
  endtask

  // one clock: check in_ready, clock both DUTs and the model, check outputs
  task automatic step();
    #1;
    chk("a_in_ready", 64'(a_ir), 64'(!e_v[0] || a_or));
    chk("b_in_ready", 64'(b_ir), 64'(!e_v[1] || b_or));
    @(posedge clk);
    if (rst) mreset();
    else begin
      mdl(0, 16, 1, 64'(a_din), a_iv, a_mode, int'(a_sel), int'(a_cfg), a_or);
      mdl(1, 10, 4, 64'(b_din), b_iv, b_mode, int'(b_sel), int'(b_cfg), b_or);
    end
    #1;
    chk("a_out_valid", 64'(a_ov), 64'(e_v[0]));
    chk("b_out_valid", 64'(b_ov), 64'(e_v[1]));
    if (e_v[0]) begin
      chk("a_outd", 64'(a_d), 64'(e_d[0][0]));
      chk("a_out_ch", 64'(a_ch), 64'(e_ch[0]));
      chk("a_sel_err", 64'(a_err), 64'(e_err[0]));
      chk("a_scan_wrap", 64'(a_wrap), 64'(e_wrap[0]));
    end
    if (e_v[1]) begin
      chk("b_outd", 64'(b_d), 64'(e_d[1]));
      chk("b_out_ch", 64'(b_ch), 64'(e_ch[1]));
      chk("b_sel_err", 64'(b_err), 64'(e_err[1]));
      chk("b_scan_wrap", 64'(b_wrap), 64'(e_wrap[1]));
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] din;
    logic        exp_d;
  } vec_t;

  typedef struct {
    logic [3:0]  sel;
    logic [39:0] din;
    logic [3:0]  exp_d;
    logic        exp_err;
  } vecb_t;

  vec_t  tab[256];
  vecb_t tabb[4];

  initial begin
    // table A: one-hot datain shifted once per 16 selects
    for (int j = 0; j < 16; j++)
      for (int s = 0; s < 16; s++)
        tab[j*16+s] = '{sel: 4'(s), din: 16'(16'h0001 << j), exp_d: (s == j)};
    tabb[0] = '{sel: 4'd12, din: 40'h00_A000_0000, exp_d: 4'h0, exp_err: 1'b1};
    tabb[1] = '{sel: 4'd7,  din: 40'h00_A000_0000, exp_d: 4'hA, exp_err: 1'b0};
    tabb[2] = '{sel: 4'd0,  din: 40'h12_3456_789C, exp_d: 4'hC, exp_err: 1'b0};
    tabb[3] = '{sel: 4'd9,  din: 40'h52_3456_789C, exp_d: 4'h5, exp_err: 1'b0};

    mreset();
    rst = 1'b1;
    a_din = '0; a_iv = 0; a_mode = 0; a_sel = '0; a_cfg = 8'd1; a_or = 1;
    b_din = '0; b_iv = 0; b_mode = 0; b_sel = '0; b_cfg = 8'd1; b_or = 1;

    // reset state
    repeat (2) begin
      step();
      chk("rst_a_valid", 64'(a_ov), 64'd0);
      chk("rst_a_outd", 64'(a_d), 64'd0);
      chk("rst_b_valid", 64'(b_ov), 64'd0);
    end
    rst = 1'b0;

    // FIXED sweep from table
    a_iv = 1;
    for (int v = 0; v < 256; v++) begin
      a_sel = tab[v].sel; a_din = tab[v].din;
      step();
      chk("sweep_outd", 64'(a_d), 64'(tab[v].exp_d));
      chk("sweep_ch", 64'(a_ch), 64'(tab[v].sel));
    end

    // backpressure
    a_sel = 4'd3; a_din = 16'h0008;
    step();
    a_or = 0; a_sel = 4'd5; a_din = 16'h0028;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_in_ready", 64'(a_ir), 64'd0);
      chk("bp_outd", 64'(a_d), 64'd1);
      chk("bp_ch", 64'(a_ch), 64'd3);
    end
    a_or = 1;
    step();
    chk("bp_next_ch", 64'(a_ch), 64'd5);

    // SCAN dwell 2 with wrap
    a_iv = 0; step();
    a_iv = 1; a_mode = 1; a_cfg = 8'd2; a_din = 16'hA5C3;
    for (int k = 0; k < 33; k++) begin
      step();
      chk("scan2_ch", 64'(a_ch), 64'((k / 2) % 16));
      chk("scan2_wrap", 64'(a_wrap), 64'(k == 31));
    end

    // dwell zero, then mode switches
    a_mode = 0; a_iv = 0; step();
    a_mode = 1; a_iv = 1; a_cfg = 8'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("dw0_ch", 64'(a_ch), 64'(k));
    end
    a_mode = 0; a_sel = 4'd9; step();
    chk("fix9_ch", 64'(a_ch), 64'd9);
    a_mode = 1; step();
    chk("rescan_ch", 64'(a_ch), 64'd0);
    a_iv = 0; a_mode = 0; step();

    // out-of-range / 4-bit table on DUT B
    b_iv = 1;
    for (int v = 0; v < 4; v++) begin
      b_sel = tabb[v].sel; b_din = tabb[v].din;
      step();
      chk("oor_outd", 64'(b_d), 64'(tabb[v].exp_d));
      chk("oor_err", 64'(b_err), 64'(tabb[v].exp_err));
    end
    b_iv = 0; step();

    // reset mid-stream in SCAN
    a_iv = 1; a_mode = 1; a_cfg = 8'd3;
    for (int k = 0; k < 13; k++) step();
    chk("pre_rst_ch", 64'(a_ch), 64'd4);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(a_ov), 64'd0);
    mreset();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ch", 64'(a_ch), 64'd0);
    chk("post_rst_wrap", 64'(a_wrap), 64'd0);
    chk("post_rst_valid", 64'(a_ov), 64'd1);

    // randomized run against the model
    for (int c = 0; c < 2000; c++) begin
      a_din = 16'($urandom); b_din = {8'($urandom), 32'($urandom)};
      a_iv = 1'($urandom); b_iv = 1'($urandom);
      a_or = ($urandom_range(0, 3) != 0); b_or = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a_mode = ~a_mode;
      if ($urandom_range(0, 15) == 0) b_mode = ~b_mode;
      a_sel = 4'($urandom); b_sel = 4'($urandom);
      if ($urandom_range(0, 31) == 0) a_cfg = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) b_cfg = 8'($urandom_range(0, 4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
